// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite renderer: colour format,
// transparency key and the per-pixel control bundle carried down the pipe.
package sprite_pkg;

   localparam int COLOR_W  = 12;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   typedef logic [COLOR_W-1:0] color_t;

   localparam color_t KEY_COLOR = 12'hF0F;

   typedef struct packed {
      logic hit;
      logic hs;
      logic vs;
      logic de;
   } pix_ctl_t;

   // Blanked pixel: syncs idle high, no display, no sprite.
   localparam pix_ctl_t CTL_IDLE = '{hit: 1'b0, hs: 1'b1, vs: 1'b1, de: 1'b0};

   function automatic logic in_box(input logic [9:0] dx, input logic [9:0] dy,
                                   input int w, input int h);
      return (dx < 10'(w)) && (dy < 10'(h));
   endfunction

endpackage

// File: rtl/sprite_render_pipe_if.sv
// Sprite BRAM read port: the renderer is the master, the memory the slave.
interface sprite_render_pipe_if #(parameter int ADDR_W = 16);

   logic                  bram_en;
   logic [ADDR_W-1:0]     bram_addr;
   sprite_pkg::color_t    bram_dout;

   modport master (output bram_en, output bram_addr, input bram_dout);
   modport slave  (input bram_en, input bram_addr, output bram_dout);

endinterface

// File: rtl/sprite_delay_line.sv
// Enabled shift register; every stage resets to RESET_VAL so a flushed
// pipe carries only inactive pixels.
module sprite_delay_line #(
   parameter int               WIDTH     = 4,
   parameter int               DEPTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

   always_comb begin
      stage_d = stage_q;
      if (en) begin
         stage_d[0] = d;
         for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) stage_q <= {DEPTH{RESET_VAL}};
      else     stage_q <= stage_d;
   end

   assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/sprite_render_pipe.sv
// Per-pixel sprite renderer: hit test + BRAM address, delay-matched syncs,
// colour-key output stage and a frame-synchronous position register.
module sprite_render_pipe
   import sprite_pkg::*;
#(
   parameter int SPR_W    = 40,
   parameter int SPR_H    = 31,
   parameter int ADDR_W   = 16,
   parameter int BRAM_LAT = 2,
   parameter int COMMIT_Y = 480
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  pix_en,
   input  logic [9:0]            drawX,
   input  logic [9:0]            drawY,
   input  logic                  hs_in,
   input  logic                  vs_in,
   input  logic                  de_in,
   input  logic [9:0]            pos_left,
   input  logic [9:0]            pos_upper,
   input  logic                  pos_wr,
   output logic                  pos_busy,
   sprite_render_pipe_if.master  bram,
   input  color_t                bg_color,
   output color_t                color_out,
   output logic                  hs_out,
   output logic                  vs_out,
   output logic                  de_out,
   output logic                  hit_out
);

   localparam logic [9:0] COMMIT_ROW = 10'(COMMIT_Y);

   logic [9:0]        pend_left_q, pend_left_d, pend_upper_q, pend_upper_d;
   logic [9:0]        act_left_q, act_left_d, act_upper_q, act_upper_d;
   logic              spr_en_q, spr_en_d, pos_busy_q, pos_busy_d;
   logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
   color_t            color_q, color_d;
   pix_ctl_t          out_q, out_d, ctl_in, ctl_dly;

   logic [9:0]        dx, dy;
   logic [19:0]       lin_addr;
   logic              hit, commit_tick;

   assign commit_tick = pix_en && (drawY == COMMIT_ROW) && (drawX == 10'd0);

   // Commit only when something is pending, so a reset sprite stays hidden
   // across frame boundaries until game logic actually places it.
   always_comb begin
      pend_left_d  = pend_left_q;
      pend_upper_d = pend_upper_q;
      act_left_d   = act_left_q;
      act_upper_d  = act_upper_q;
      spr_en_d     = spr_en_q;
      pos_busy_d   = pos_busy_q;
      if (pos_wr) begin
         pend_left_d  = pos_left;
         pend_upper_d = pos_upper;
         pos_busy_d   = 1'b1;
      end
      if (commit_tick && (pos_busy_q || pos_wr)) begin
         act_left_d  = pos_wr ? pos_left  : pend_left_q;
         act_upper_d = pos_wr ? pos_upper : pend_upper_q;
         spr_en_d    = 1'b1;
         pos_busy_d  = 1'b0;
      end
   end

   // Offsets wrap mod 2^10, so pixels left of / above the sprite miss.
   always_comb begin
      dx          = drawX - act_left_q;
      dy          = drawY - act_upper_q;
      hit         = spr_en_q && de_in && in_box(dx, dy, SPR_W, SPR_H);
      lin_addr    = 20'(dy) * 20'(SPR_W) + 20'(dx);
      bram_addr_d = bram_addr_q;
      if (pix_en) bram_addr_d = hit ? ADDR_W'(lin_addr) : '0;
   end

   always_comb begin
      ctl_in     = CTL_IDLE;
      ctl_in.hit = hit;
      ctl_in.hs  = hs_in;
      ctl_in.vs  = vs_in;
      ctl_in.de  = de_in;
   end

   // Control bits spend one tick alongside the address register plus the
   // BRAM read latency, landing in step with bram_dout.
   sprite_delay_line #(
      .WIDTH     ($bits(pix_ctl_t)),
      .DEPTH     (1 + BRAM_LAT),
      .RESET_VAL (CTL_IDLE)
   ) u_ctl_dly (
      .clk (Clk),
      .rst (Reset),
      .en  (pix_en),
      .d   (ctl_in),
      .q   (ctl_dly)
   );

   always_comb begin
      out_d   = out_q;
      color_d = color_q;
      if (pix_en) begin
         out_d = ctl_dly;
         if (!ctl_dly.de)
            color_d = '0;
         else if (ctl_dly.hit && (bram.bram_dout != KEY_COLOR))
            color_d = bram.bram_dout;
         else
            color_d = bg_color;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pend_left_q  <= '0;
         pend_upper_q <= '0;
         act_left_q   <= '0;
         act_upper_q  <= '0;
         spr_en_q     <= 1'b0;
         pos_busy_q   <= 1'b0;
         bram_addr_q  <= '0;
         color_q      <= '0;
         out_q        <= CTL_IDLE;
      end else begin
         pend_left_q  <= pend_left_d;
         pend_upper_q <= pend_upper_d;
         act_left_q   <= act_left_d;
         act_upper_q  <= act_upper_d;
         spr_en_q     <= spr_en_d;
         pos_busy_q   <= pos_busy_d;
         bram_addr_q  <= bram_addr_d;
         color_q      <= color_d;
         out_q        <= out_d;
      end
   end

   assign bram.bram_en   = pix_en;
   assign bram.bram_addr = bram_addr_q;
   assign pos_busy       = pos_busy_q;
   assign color_out      = color_q;
   assign hs_out         = out_q.hs;
   assign vs_out         = out_q.vs;
   assign de_out         = out_q.de;
   assign hit_out        = out_q.hit;

endmodule

// File: tb/tb_sprite_render_pipe.sv
// Randomised and directed bench for sprite_render_pipe against a
// pixel-level reference model with a behavioural BRAM.
module tb_sprite_render_pipe;
   import sprite_pkg::*;

   localparam int SPR_W = 40, SPR_H = 31, ADDR_W = 16, LAT = 2, COMMIT_Y = 480;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic       Reset, pix_en, hs_in, vs_in, de_in, pos_wr, pos_busy;
   logic [9:0] drawX, drawY, pos_left, pos_upper;
   color_t     bg_color, color_out;
   logic       hs_out, vs_out, de_out, hit_out;

   sprite_render_pipe_if #(.ADDR_W(ADDR_W)) bram ();

   sprite_render_pipe #(.SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W),
                        .BRAM_LAT(LAT), .COMMIT_Y(COMMIT_Y)) dut (
      .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .drawX(drawX), .drawY(drawY),
      .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in), .pos_left(pos_left),
      .pos_upper(pos_upper), .pos_wr(pos_wr), .pos_busy(pos_busy), .bram(bram),
      .bg_color(bg_color), .color_out(color_out), .hs_out(hs_out),
      .vs_out(vs_out), .de_out(de_out), .hit_out(hit_out));

   // Behavioural BRAM with LAT-tick read latency, clock-enabled by bram_en.
   color_t mem [0:(1<<ADDR_W)-1];
   color_t rd1, rd2;
   always @(posedge Clk) if (bram.bram_en) begin
      rd1 <= mem[bram.bram_addr];
      rd2 <= rd1;
   end
   assign bram.bram_dout = (LAT == 2) ? rd2 : rd1;

   typedef struct { bit hit; bit hs; bit vs; bit de; int addr; } ent_t;
   ent_t hist[$];
   int   m_left, m_upper, p_left, p_upper;
   bit   m_en, m_busy;
   bit   exp_hit, exp_hs, exp_vs, exp_de;
   color_t exp_color;
   int   exp_addr;
   int   n_tests = 0, n_fail = 0;

   task automatic model_reset();
      ent_t idle = '{hit: 0, hs: 1, vs: 1, de: 0, addr: 0};
      hist.delete();
      for (int i = 0; i < LAT + 1; i++) hist.push_back(idle);
      m_left = 0; m_upper = 0; p_left = 0; p_upper = 0; m_en = 0; m_busy = 0;
      exp_hit = 0; exp_hs = 1; exp_vs = 1; exp_de = 0; exp_color = '0; exp_addr = 0;
   endtask

   // Drive one clock of inputs and advance the reference model.
   task automatic tick(input int x, input int y, input bit de, input bit pe = 1'b1,
                       input color_t bg = 12'h00A, input bit hs = 1'b1, input bit vs = 1'b1,
                       input bit wr = 1'b0, input int wl = 0, input int wu = 0);
      ent_t n, e;
      bit   commit;
      drawX = x[9:0]; drawY = y[9:0]; de_in = de; pix_en = pe; bg_color = bg;
      hs_in = hs; vs_in = vs; pos_wr = wr; pos_left = wl[9:0]; pos_upper = wu[9:0];
      @(posedge Clk);
      if (pe) begin
         n.hit = m_en && de && x >= m_left && x < m_left + SPR_W &&
                 y >= m_upper && y < m_upper + SPR_H;
         n.addr = n.hit ? (y - m_upper) * SPR_W + (x - m_left) : 0;
         n.hs = hs; n.vs = vs; n.de = de;
         hist.push_back(n);
         e = hist.pop_front();
         exp_hit = e.hit; exp_hs = e.hs; exp_vs = e.vs; exp_de = e.de;
         exp_color = !e.de ? 12'h000 : (e.hit && mem[e.addr] != KEY_COLOR) ? mem[e.addr] : bg;
         exp_addr = n.addr;
      end
      commit = pe && y == COMMIT_Y && x == 0 && (m_busy || wr);
      if (commit) begin
         m_left = wr ? wl : p_left; m_upper = wr ? wu : p_upper;
         m_en = 1; m_busy = 0;
         if (wr) begin p_left = wl; p_upper = wu; end
      end else if (wr) begin
         p_left = wl; p_upper = wu; m_busy = 1;
      end
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1; pos_wr = 1'b0; pix_en = 1'($urandom); drawX = 10'd300; drawY = 10'd120;
      @(posedge Clk);
      model_reset();
      #1;
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      tick(5, 300, 1, 1, 12'h00A, 1, 1, 1, 30, 20);
      tick(0, 480, 1);
      for (int i = 0; i < 10; i++) tick(30 + i, 25, 1);
      tick(300, 120, 1);
      do_reset();
      n_tests += 6;
      if (color_out !== 12'h000) begin n_fail++; $display("FAIL rst_color got %h exp 000", color_out); end
      if (hs_out !== 1'b1 || vs_out !== 1'b1) begin n_fail++; $display("FAIL rst_sync got hs=%b vs=%b exp 1 1", hs_out, vs_out); end
      if (de_out !== 1'b0) begin n_fail++; $display("FAIL rst_de got %b exp 0", de_out); end
      if (hit_out !== 1'b0) begin n_fail++; $display("FAIL rst_hit got %b exp 0", hit_out); end
      if (pos_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", pos_busy); end
      if (bram.bram_addr !== '0) begin n_fail++; $display("FAIL rst_addr got %0d exp 0", bram.bram_addr); end
      for (int j = 0; j <= LAT + 1; j++) begin
         tick(200 + j, 100, 1, 1, 12'h00A, 0);
         n_tests++;
         if (de_out !== (j == LAT + 1) || hs_out !== (j != LAT + 1)) begin
            n_fail++; $display("FAIL rst_flush j=%0d got de=%b hs=%b exp de=%b hs=%b", j, de_out, hs_out, j == LAT + 1, j != LAT + 1);
         end
      end
      for (int i = 0; i < 400; i++) begin
         if (i == 200) tick(0, 480, 1);
         else tick($urandom_range(0, 99), $urandom_range(0, 60), 1);
         n_tests++;
         if (hit_out !== 1'b0) begin n_fail++; $display("FAIL rst_hidden i=%0d got %b exp 0", i, hit_out); end
      end
   endtask

   task automatic test_pos_commit();
      tick(10, 200, 1, 1, 12'h00A, 1, 1, 1, 100, 50);
      n_tests++;
      if (pos_busy !== 1'b1) begin n_fail++; $display("FAIL commit_busy_set got %b exp 1", pos_busy); end
      for (int i = 0; i < 30; i++) begin
         if (i == 10) tick(0, 480, 1, 0);
         else if (i == 20) tick(100, 50, 1);
         else tick($urandom_range(200, 639), $urandom_range(200, 479), 1);
         n_tests++;
         if (pos_busy !== 1'b1 || hit_out !== 1'b0) begin
            n_fail++; $display("FAIL commit_pending i=%0d got busy=%b hit=%b exp 1 0", i, pos_busy, hit_out);
         end
      end
      tick(0, 480, 1);
      n_tests++;
      if (pos_busy !== 1'b0) begin n_fail++; $display("FAIL commit_busy_clr got %b exp 0", pos_busy); end
      tick(100, 50, 1);
      for (int j = 1; j <= LAT + 1; j++) begin
         tick(600, 300, 1);
         n_tests++;
         if (hit_out !== (j == LAT + 1)) begin n_fail++; $display("FAIL commit_first_hit j=%0d got %b exp %b", j, hit_out, j == LAT + 1); end
      end
   endtask

   task automatic test_addr();
      int xs [5] = '{100, 139, 140, 99, 100};
      int ys [5] = '{50, 80, 50, 50, 81};
      int ea [5] = '{0, 1239, 0, 0, 0};
      for (int i = 0; i < 5; i++) begin
         tick(xs[i], ys[i], 1);
         n_tests++;
         if (bram.bram_addr !== ADDR_W'(ea[i])) begin
            n_fail++; $display("FAIL addr (%0d,%0d) got %0d exp %0d", xs[i], ys[i], bram.bram_addr, ea[i]);
         end
      end
   endtask

   task automatic test_latency();
      int cnt = 0;
      bit seen = 0;
      mem[205] = 12'h5A5;
      for (int i = 0; i < LAT + 2; i++) tick(600, 300, 1);
      tick(105, 55, 1, 1, 12'h00A, 0);
      for (int i = 0; i < 40 && !seen; i++) begin
         bit pe = ($urandom_range(0, 2) != 0);
         tick(600, 300, 1, pe, 12'h00A, 0);
         if (pe) cnt++;
         if (hs_out === 1'b0) seen = 1;
      end
      n_tests += 2;
      if (!seen || cnt != LAT + 1) begin n_fail++; $display("FAIL hs_latency seen=%b got %0d ticks exp %0d", seen, cnt, LAT + 1); end
      if (color_out !== 12'h5A5) begin n_fail++; $display("FAIL hs_align_color got %h exp 5a5", color_out); end
   endtask

   task automatic test_transparency();
      color_t ec [3] = '{12'h00A, 12'h123, 12'h000};
      mem[5] = 12'hF0F; mem[6] = 12'h123; mem[7] = 12'h456;
      for (int t = 0; t < 3 + LAT + 1; t++) begin
         if (t < 3) tick(105 + t, 50, t != 2);
         else tick(600, 300, 1);
         if (t >= LAT + 1) begin
            n_tests++;
            if (color_out !== ec[t-LAT-1]) begin
               n_fail++; $display("FAIL transp px%0d got %h exp %h", t - LAT - 1, color_out, ec[t-LAT-1]);
            end
         end
      end
   endtask

   task automatic test_edge();
      tick(5, 300, 1, 1, 12'h00A, 1, 1, 1, 620, 100);
      tick(0, 480, 1);
      for (int i = 0; i < 66; i++) begin
         int x = (i < 40) ? 600 + i : i - 40;
         int ea = (x >= 620) ? 400 + (x - 620) : 0;
         tick(x, 110, 1);
         n_tests += 2;
         if (bram.bram_addr !== ADDR_W'(ea)) begin n_fail++; $display("FAIL edge_addr x=%0d got %0d exp %0d", x, bram.bram_addr, ea); end
         if (hit_out !== exp_hit) begin n_fail++; $display("FAIL edge_hit i=%0d got %b exp %b", i, hit_out, exp_hit); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         bit wr = ($urandom_range(0, 99) < 3);
         bit cm = ($urandom_range(0, 99) < 5);
         int x = cm ? 0 : $urandom_range(0, 799);
         int y = cm ? COMMIT_Y : $urandom_range(0, 524);
         tick(x, y, 1'($urandom), $urandom_range(0, 3) != 0, color_t'($urandom),
              1'($urandom), 1'($urandom), wr, $urandom_range(0, 639), $urandom_range(0, 479));
         n_tests++;
         if (color_out !== exp_color || hs_out !== exp_hs || vs_out !== exp_vs ||
             de_out !== exp_de || hit_out !== exp_hit || pos_busy !== m_busy ||
             bram.bram_addr !== ADDR_W'(exp_addr)) begin
            n_fail++;
            $display("FAIL rand i=%0d got c=%h hs=%b vs=%b de=%b hit=%b busy=%b a=%0d exp c=%h hs=%b vs=%b de=%b hit=%b busy=%b a=%0d",
                     i, color_out, hs_out, vs_out, de_out, hit_out, pos_busy, bram.bram_addr,
                     exp_color, exp_hs, exp_vs, exp_de, exp_hit, m_busy, exp_addr);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++)
         mem[i] = ($urandom_range(0, 7) == 0) ? KEY_COLOR : color_t'($urandom);
      Reset = 1'b1; pix_en = 1'b0; drawX = '0; drawY = '0; hs_in = 1'b1; vs_in = 1'b1;
      de_in = 1'b0; pos_left = '0; pos_upper = '0; pos_wr = 1'b0; bg_color = '0;
      repeat (2) @(posedge Clk);
      do_reset();
      test_reset();
      test_pos_commit();
      test_addr();
      test_latency();
      test_transparency();
      test_edge();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_render_pipe.md
Name: sprite_render_pipe

Overview:
- Per-pixel sprite renderer that sits between the VGA timing generator and the colour mapper.
- Takes the current drawX/drawY and hit-tests them against one sprite rectangle.
- Reads the sprite's colour from the sprite BRAM and keys out transparent pixels.
- Outputs the final colour with the sync and display-enable signals delay-matched to it.
- Owns a frame-synchronous sprite-position register, so game logic can move the sprite at any time without tearing.

Parameters:
- SPR_W, 40: sprite width in pixels.
- SPR_H, 31: sprite height in pixels.
- ADDR_W, 16: BRAM address width; must satisfy SPR_W*SPR_H <= 2**ADDR_W.
- BRAM_LAT, 2: BRAM read latency in pix_en ticks (1 or 2).
- COMMIT_Y, 480: drawY line on which a pending position is committed.

Ports:
- Clk, input, 1: system clock.
- Reset, input, 1: synchronous, active-high.
- pix_en, input, 1: pixel tick; the pipeline advances only when it is 1.
- drawX, input, 10: current pixel column.
- drawY, input, 10: current pixel row.
- hs_in, input, 1: horizontal sync, active-low.
- vs_in, input, 1: vertical sync, active-low.
- de_in, input, 1: display enable, active-high.
- pos_left, input, 10: new sprite left edge.
- pos_upper, input, 10: new sprite top edge.
- pos_wr, input, 1: one-Clk pulse that requests a position update.
- pos_busy, output, 1: an update is pending commit.
- bram_en, output, 1: BRAM clock enable; equal to pix_en.
- bram_addr, output, ADDR_W: BRAM read address, registered.
- bram_dout, input, COLOR_W: BRAM read data.
- bg_color, input, COLOR_W: background colour, sampled at the output stage.
- color_out, output, COLOR_W: final pixel colour.
- hs_out, output, 1: delayed horizontal sync.
- vs_out, output, 1: delayed vertical sync.
- de_out, output, 1: delayed display enable.
- hit_out, output, 1: the delayed pixel lies inside the sprite.

Behaviour:
- Clocking: one clock (Clk). Reset is synchronous and active-high. All state is updated on Clk edges, and pipeline registers load only when pix_en=1.
- Position register:
  - pos_wr latches pos_left/pos_upper into the pending registers and sets pos_busy=1.
  - A second pos_wr while busy overwrites the pending value (last write wins).
  - Commit happens on the pix_en tick where drawY==COMMIT_Y and drawX==0. Active := pending, spr_en := 1, pos_busy := 0.
  - If pos_wr coincides with the commit tick, the new input value is committed directly and pos_busy=0.
- Hit test (stage 1):
  - dx = drawX - left and dy = drawY - upper, computed mod 2^10 (unsigned wrap).
  - hit = spr_en & de_in & (dx < SPR_W) & (dy < SPR_H). Negative offsets wrap to large values and miss.
  - There is no wrap-around across screen edges.
  - On a hit, bram_addr := dy*SPR_W + dx, truncated to ADDR_W. On a miss, bram_addr := 0.
- Delay: hit, hs, vs and de travel through a shift register of depth 1+BRAM_LAT ticks. The total latency from drawX/drawY to color_out is 1+BRAM_LAT pix_en ticks, and all outputs are mutually aligned.
- Output stage (registered):
  - de=0 gives color_out = 0.
  - Otherwise, hit=1 and bram_dout != KEY_COLOR gives color_out = bram_dout.
  - Otherwise color_out = bg_color.
- Reset values:
  - color_out=0, hs_out=1, vs_out=1, de_out=0, hit_out=0.
  - bram_addr=0, pos_busy=0, spr_en=0 (sprite hidden), active and pending positions = 0.
  - All delay stages are cleared to these same inactive values.
- Reset mid-frame: the pipeline is flushed and outputs stay inactive until 1+BRAM_LAT ticks after release. The sprite stays hidden until the next commit.
- pix_en=0: all pipeline and output registers hold. pos_wr capture still occurs.

Decomposition:
- sprite_pkg holds:
  - COLOR_W = 12 and KEY_COLOR = 12'hF0F.
  - H_ACTIVE = 640 and V_ACTIVE = 480.
  - A typedef color_t for COLOR_W-bit colours.
- One sub-module, sprite_delay_line. It is a parameterised (WIDTH, DEPTH, RESET_VAL) enabled shift register and is used for {hit, hs, vs, de}.

Test Plan:
- Reset asserted mid-line, then released -> hs_out=vs_out=1, de_out=0, color_out=0, pos_busy=0. hit_out stays 0 for a full frame with no pos_wr.
- pos_wr with (100,50) at drawY=200 -> pos_busy=1 through the tick at (drawX=0, drawY=480), then 0. hit_out is first 1 at (100,50) of the following frame.
- Sprite at (100,50):
  - drawX/drawY (100,50) -> bram_addr=0.
  - (139,80) -> bram_addr=1239.
  - (140,50), (99,50) and (100,81) -> miss, bram_addr=0.
- BRAM_LAT=2 -> a falling edge on hs_in appears on hs_out exactly 3 pix_en ticks later, in the same cycle as that pixel's colour. Inserting pix_en=0 gaps does not change the tick count.
- Transparency, with the sprite hit and bg_color=12'h00A:
  - bram_dout=12'hF0F -> color_out=12'h00A.
  - bram_dout=12'h123 -> 12'h123.
  - de_in=0 at that pixel -> color_out=0.
- Sprite at left=620 -> hits for drawX 620..639 only. drawX=0..19 miss (dx wraps to 404..423).
